// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   Op encodings, controller state encoding, latency constants.
//   Optional feature macro: MDU_DIV_EN (adds the DIV state and divider).
// -----------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1
    } state_e;
`endif

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] MUL_CYCLES = 4'd5;
    localparam logic [CNT_W-1:0] DIV_CYCLES = 4'd10;

endpackage

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- latency counter and state machine for the MDU.
//   Optional feature macro: MDU_DIV_EN (adds DIV state / i_start_div).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no operation in flight; accepts a start
//   ST_MUL  | multiply in flight, counting MUL_CYCLES down to 1
//   ST_DIV  | divide in flight, counting DIV_CYCLES down to 1 (MDU_DIV_EN)
//
// Ports:
//   i_clk        clock
//   i_reset_n    synchronous active-low reset
//   i_start_mul  accepted multiply start (already qualified with idle)
//   i_start_div  accepted divide start (MDU_DIV_EN builds only)
//   o_busy       high whenever the state is not ST_IDLE
//   o_commit     high in the last busy cycle; the next edge commits HI/LO
// -----------------------------------------------------------------------------
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_start_mul,
`ifdef MDU_DIV_EN
    input  logic i_start_div,
`endif
    output logic o_busy,
    output logic o_commit
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start_mul) begin
                    w_state_nxt = ST_MUL;
                    w_cnt_nxt   = MUL_CYCLES;
                end
`ifdef MDU_DIV_EN
                else if (i_start_div) begin
                    w_state_nxt = ST_DIV;
                    w_cnt_nxt   = DIV_CYCLES;
                end
`endif
            end
            ST_MUL: begin
                if (r_cnt == 4'd1) begin
                    o_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
`ifdef MDU_DIV_EN
            ST_DIV: begin
                if (r_cnt == 4'd1) begin
                    o_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- MIPS-style multiply/divide unit with HI/LO registers.
//   Results are computed in the start cycle into a shadow register and
//   committed to HI/LO after a fixed latency, emulating a multi-cycle unit.
//   Optional feature macro: MDU_DIV_EN (DIV/DIVU support; otherwise no-ops).
//
// Ports:
//   clk    clock
//   reset  synchronous active-low reset
//   A, B   32-bit operands (rs, rt)
//   Op     0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   Start  qualifies Op for one cycle; ignored while Busy
//   Busy   operation in flight
//   HI, LO architectural result registers
// -----------------------------------------------------------------------------
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Op,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic        w_busy;
    logic        w_commit;
    logic        w_idle_start;
    logic        w_start_mul;
    logic        w_mthi;
    logic        w_mtlo;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_prod;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_sh_hi;
    logic [31:0] r_sh_lo;
    logic        r_sh_wr;

    assign w_idle_start = Start && !w_busy;
    assign w_start_mul  = w_idle_start && ((Op == OP_MULT) || (Op == OP_MULTU));
    assign w_mthi       = w_idle_start && (Op == OP_MTHI);
    assign w_mtlo       = w_idle_start && (Op == OP_MTLO);

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};
    assign w_prod   = (Op == OP_MULT) ? w_prod_s : w_prod_u;

`ifdef MDU_DIV_EN
    logic        w_start_div;
    logic        w_b_zero;
    logic        w_ovf;
    logic [31:0] w_dvs_s;
    logic [31:0] w_dvs_u;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_start_div = w_idle_start && ((Op == OP_DIV) || (Op == OP_DIVU));
    assign w_b_zero    = (B == 32'd0);
    assign w_ovf       = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    // Divisor is forced to 1 on divide-by-zero (result discarded anyway) and
    // on INT_MIN / -1, where dividing by 1 yields exactly the wrapped result
    // (quotient 0x80000000, remainder 0) without an overflowing divide.
    assign w_dvs_s = (w_b_zero || w_ovf) ? 32'd1 : B;
    assign w_dvs_u = w_b_zero ? 32'd1 : B;

    always_comb begin
        w_quo = A / w_dvs_u;
        w_rem = A % w_dvs_u;
        if (Op == OP_DIV) begin
            w_quo = $signed(A) / $signed(w_dvs_s);
            w_rem = $signed(A) % $signed(w_dvs_s);
        end
    end
`endif

    mdu_ctrl u_ctrl (
        .i_clk       (clk),
        .i_reset_n   (reset),
        .i_start_mul (w_start_mul),
`ifdef MDU_DIV_EN
        .i_start_div (w_start_div),
`endif
        .o_busy      (w_busy),
        .o_commit    (w_commit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sh_hi <= '0;
            r_sh_lo <= '0;
            r_sh_wr <= 1'b0;
        end else if (w_start_mul) begin
            r_sh_hi <= w_prod[63:32];
            r_sh_lo <= w_prod[31:0];
            r_sh_wr <= 1'b1;
        end
`ifdef MDU_DIV_EN
        else if (w_start_div) begin
            r_sh_hi <= w_rem;
            r_sh_lo <= w_quo;
            r_sh_wr <= !w_b_zero;
        end
`endif
    end

    // MTHI/MTLO need idle, so they never coincide with a commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit && r_sh_wr) begin
            r_hi <= r_sh_hi;
            r_lo <= r_sh_lo;
        end else begin
            if (w_mthi) r_hi <= A;
            if (w_mtlo) r_lo <= A;
        end
    end

    assign Busy = w_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  Op;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_tests = 0;
    int n_fail  = 0;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .Op    (Op),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Op = op; A = a; B = b; Start = 1'b1;
        tick();
        Start = 1'b0; Op = 3'd7;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; Start = 1'b0; Op = 3'd7; A = '0; B = '0;
        tick(); tick();
        reset = 1'b1;
        n_tests++;
        if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: HI=%h LO=%h Busy=%b, required 0/0/0", HI, LO, Busy);
        end
        go(3'd4, 32'hAAAA5555, 32'h0);
        go(3'd5, 32'h5555AAAA, 32'h0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_tests++;
        if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clear: HI=%h LO=%h Busy=%b, required 0/0/0", HI, LO, Busy);
        end
    endtask

    task automatic test_mult();
        int n;
        go(3'd0, 32'hFFFFFFFE, 32'h3);
        n_tests++;
        if (HI !== 32'h0 || LO !== 32'h0) begin
            n_fail++;
            $display("FAIL mult_early: HI=%h LO=%h, required 0/0 while busy", HI, LO);
        end
        wait_idle(n);
        n_tests++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL mult_busy_cycles: got %0d, required 5", n);
        end
        n_tests++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
            n_fail++;
            $display("FAIL mult_neg: HI=%h LO=%h, required ffffffff/fffffffa", HI, LO);
        end
        go(3'd0, 32'h80000000, 32'h80000000);
        wait_idle(n);
        n_tests++;
        if (HI !== 32'h40000000 || LO !== 32'h0) begin
            n_fail++;
            $display("FAIL mult_minmin: HI=%h LO=%h, required 40000000/00000000", HI, LO);
        end
    endtask

    task automatic test_multu();
        int n;
        go(3'd1, 32'hFFFFFFFF, 32'h2);
        wait_idle(n);
        n_tests++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL multu_busy_cycles: got %0d, required 5", n);
        end
        n_tests++;
        if (HI !== 32'h1 || LO !== 32'hFFFFFFFE) begin
            n_fail++;
            $display("FAIL multu: HI=%h LO=%h, required 00000001/fffffffe", HI, LO);
        end
    endtask

    task automatic test_mthi_mtlo();
        go(3'd4, 32'h12345678, 32'h0);
        n_tests++;
        if (HI !== 32'h12345678 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi: HI=%h Busy=%b, required 12345678/0", HI, Busy);
        end
        go(3'd5, 32'hCAFEF00D, 32'h0);
        n_tests++;
        if (LO !== 32'hCAFEF00D || HI !== 32'h12345678 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo: HI=%h LO=%h Busy=%b, required 12345678/cafef00d/0", HI, LO, Busy);
        end
        go(3'd6, 32'hDEADBEEF, 32'h1);
        go(3'd7, 32'hDEADBEEF, 32'h1);
        n_tests++;
        if (LO !== 32'hCAFEF00D || HI !== 32'h12345678 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL noop_op: HI=%h LO=%h Busy=%b, required 12345678/cafef00d/0", HI, LO, Busy);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        go(3'd4, 32'h12345678, 32'h0);
        n_tests++;
        if (HI !== 32'h12345678) begin
            n_fail++;
            $display("FAIL busy_mthi_pre: HI=%h, required 12345678", HI);
        end
        go(3'd0, 32'h3, 32'h4);
        tick();
        Op = 3'd0; A = 32'h5; B = 32'h5; Start = 1'b1;
        tick();
        Op = 3'd5; A = 32'hDEAD0000; Start = 1'b1;
        tick();
        Op = 3'd4; A = 32'hBEEF0000; Start = 1'b1;
        tick();
        Start = 1'b0; Op = 3'd7;
        wait_idle(n);
        n_tests++;
        if (n + 4 !== 5) begin
            n_fail++;
            $display("FAIL busy_ignore_cycles: got %0d, required 5", n + 4);
        end
        n_tests++;
        if (HI !== 32'h0 || LO !== 32'hC) begin
            n_fail++;
            $display("FAIL busy_ignore_result: HI=%h LO=%h, required 00000000/0000000c", HI, LO);
        end
    endtask

    task automatic test_operand_hold();
        int n;
        go(3'd1, 32'd10, 32'd20);
        A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        wait_idle(n);
        n_tests++;
        if (HI !== 32'h0 || LO !== 32'hC8) begin
            n_fail++;
            $display("FAIL operand_hold: HI=%h LO=%h, required 00000000/000000c8", HI, LO);
        end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        int n;
        go(3'd2, 32'hFFFFFFF9, 32'h2);
        wait_idle(n);
        n_tests++;
        if (n !== 10) begin
            n_fail++;
            $display("FAIL div_busy_cycles: got %0d, required 10", n);
        end
        n_tests++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL div_neg: HI=%h LO=%h, required ffffffff/fffffffd", HI, LO);
        end
        go(3'd3, 32'h7, 32'h0);
        wait_idle(n);
        n_tests++;
        if (n !== 10) begin
            n_fail++;
            $display("FAIL divu_zero_cycles: got %0d, required 10", n);
        end
        n_tests++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL divu_zero_keep: HI=%h LO=%h, required ffffffff/fffffffd", HI, LO);
        end
        go(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        n_tests++;
        if (HI !== 32'h0 || LO !== 32'h80000000) begin
            n_fail++;
            $display("FAIL div_ovf: HI=%h LO=%h, required 00000000/80000000", HI, LO);
        end
        go(3'd3, 32'd100, 32'd7);
        wait_idle(n);
        n_tests++;
        if (HI !== 32'd2 || LO !== 32'd14) begin
            n_fail++;
            $display("FAIL divu: HI=%h LO=%h, required 00000002/0000000e", HI, LO);
        end
        go(3'd3, 32'hFFFFFFF9, 32'h2);
        wait_idle(n);
        n_tests++;
        if (HI !== 32'h1 || LO !== 32'h7FFFFFFC) begin
            n_fail++;
            $display("FAIL divu_big: HI=%h LO=%h, required 00000001/7ffffffc", HI, LO);
        end
    endtask
`else
    task automatic test_div_disabled();
        go(3'd4, 32'h11112222, 32'h0);
        go(3'd5, 32'h33334444, 32'h0);
        go(3'd2, 32'hFFFFFFF9, 32'h2);
        n_tests++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL div_off_busy: Busy=%b, required 0", Busy);
        end
        go(3'd3, 32'd100, 32'd7);
        tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
        n_tests++;
        if (HI !== 32'h11112222 || LO !== 32'h33334444 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL div_off_keep: HI=%h LO=%h Busy=%b, required 11112222/33334444/0", HI, LO, Busy);
        end
    endtask
`endif

    task automatic test_reset_abort();
        go(3'd4, 32'h0BADF00D, 32'h0);
        go(3'd5, 32'h600DF00D, 32'h0);
`ifdef MDU_DIV_EN
        go(3'd3, 32'd100, 32'd7);
`else
        go(3'd1, 32'd100, 32'd7);
`endif
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_tests++;
        if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: HI=%h LO=%h Busy=%b, required 0/0/0", HI, LO, Busy);
        end
        for (int i = 0; i < 12; i++) tick();
        n_tests++;
        if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_commit: HI=%h LO=%h Busy=%b, required 0/0/0", HI, LO, Busy);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_mthi_mtlo();
        test_start_while_busy();
        test_operand_hold();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL be a single-clock domain with a synchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: the rising edge samples every input and updates every register.
REQ-003 Port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port A, input, 32 bits: operand A, taken from register-file read port A (rs).
REQ-005 Port B, input, 32 bits: operand B, taken from register-file read port B (rt).
REQ-006 Port Op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
REQ-007 Port Start, input, 1 bit: qualifies Op for one cycle.
REQ-008 Port Busy, output, 1 bit: high while an operation is in flight.
REQ-009 Port HI, output, 32 bits: HI register value.
REQ-010 Port LO, output, 32 bits: LO register value.

Function
REQ-011 The state machine SHALL have three states: IDLE, MUL and DIV; Busy SHALL be 1 exactly when the state is not IDLE.
REQ-012 In IDLE, Start=1 with Op MULT or MULTU SHALL latch the 64-bit product into a shadow register, load the counter with 5, and move to MUL.
REQ-013 In IDLE, Start=1 with Op DIV or DIVU SHALL latch the quotient and remainder into the shadow register, load the counter with 10, and move to DIV.
REQ-014 In MUL or DIV, the counter SHALL decrement once per cycle; when it reaches 1 the next edge SHALL commit the shadow value to HI/LO and return to IDLE.
REQ-015 Timing SHALL be: Start sampled at edge t; Busy=1 for edges t+1 through t+N (N=5 for multiply, 10 for divide); HI/LO and Busy=0 become visible together after edge t+N.
REQ-016 MULT SHALL use signed operands and MULTU unsigned operands; the product SHALL be 64 bits, with HI taking bits [63:32] and LO taking bits [31:0].
REQ-017 For DIV and DIVU, LO SHALL receive the quotient and HI the remainder; for DIV the quotient SHALL truncate toward zero and the remainder SHALL take the sign of A.
REQ-018 Dividing by zero (B=0) SHALL still run the full 10 cycles with Busy asserted, but HI and LO SHALL stay unchanged.
REQ-019 A signed divide of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-020 MTHI and MTLO with Start=1 in IDLE SHALL write A into HI or LO on that same edge and leave Busy at 0.
REQ-021 Start=1 while Busy=1 SHALL be ignored, for every Op, including MTHI and MTLO.
REQ-022 Operands SHALL be sampled only on the Start edge; changes to A and B while Busy=1 SHALL have no effect.
REQ-023 HI and LO SHALL be driven straight from registers, with no combinational path from any input.

Reset
REQ-024 On a rising edge with reset=0, the block SHALL set HI=0, LO=0, Busy=0, state=IDLE and counter=0.
REQ-025 Reset SHALL take priority over Start and over any in-flight commit; asserting reset mid-operation SHALL abort it and discard the shadow value.

Configuration
REQ-026 With the macro MDU_DIV_EN defined, the block SHALL include the DIV state and support DIV and DIVU.
REQ-027 With MDU_DIV_EN undefined, DIV and DIVU SHALL be treated as no-ops (no Busy, HI/LO unchanged), and the DIV state and divider logic SHALL not be built.

Structure
REQ-028 A shared package mdu_pkg SHALL hold the Op encodings, the state encoding, and the latency constants MUL_CYCLES=5 and DIV_CYCLES=10.
REQ-029 The counter plus the state machine SHALL be a single sub-module named mdu_ctrl; the arithmetic and the HI/LO registers SHALL stay in mdu.

Verification
REQ-030 MULT with A=0xFFFFFFFE (-2) and B=3 -> Busy high for exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-031 MULTU with A=0xFFFFFFFF and B=2 -> after 5 cycles, HI=0x00000001 and LO=0xFFFFFFFE.
REQ-032 DIV with A=0xFFFFFFF9 (-7) and B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIVU with A=7 and B=0 -> Busy for 10 cycles, then HI/LO unchanged.
REQ-033 MTHI with A=0x12345678 while idle, then MULT pulsed at busy cycle 2 -> HI=0x12345678 on the next edge and the second Start ignored.
REQ-034 DIV started, reset=0 at busy cycle 4 -> on the next edge HI=0, LO=0, Busy=0, with no later commit.
REQ-035 Build without MDU_DIV_EN and issue DIV with Start=1 -> Busy stays 0 and HI/LO are unchanged.
